aes_round_sequencer: RTL and testbench

Control FSM for the AES-128 encryption datapath. On `start`, it sequences the registered stage units (SubBytes, ShiftRows, MixColumns, AddRoundKey) through the initial key addition, NR−1 full rounds and a final round without MixColumns. Each stage is driven with a one-cycle `*EN` pulse, and the sequencer waits for that unit's `*Valid` before moving on. It sits between the top-level cipher wrapper and the stage units, and also steers the AddRoundKey input mux and the round-key index.

---
 rtl/aes_pkg.sv | 22 ++
 rtl/stage_handshake.sv | 53 +++++
 rtl/aes_round_sequencer.sv | 145 ++++++++++++++
 tb/tb_aes_round_sequencer.sv | 265 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/aes_pkg.sv
// Shared types and constants for the AES-128 round sequencer.
// State encoding, AddRoundKey source select codes and round-index width.
package aes_pkg;

    localparam int AES128_NR = 10;
    localparam int RIDX_W    = 4;

    typedef enum logic [2:0] {
        IDLE,
        ARK0,
        SB,
        SR,
        MC,
        ARK,
        FIN
    } state_t;

    localparam logic [1:0] ARK_SEL_PT = 2'd0;
    localparam logic [1:0] ARK_SEL_MC = 2'd1;
    localparam logic [1:0] ARK_SEL_SR = 2'd2;

endpackage

// File: rtl/stage_handshake.sv
// One-cycle enable pulse then wait for the stage's valid, with timeout.
// Latency: pulse the cycle after arm; fire/expired are combinational in WAIT.
module stage_handshake #(
    parameter int TMO = 15
) (
    input  logic clk,
    input  logic rst,
    input  logic arm,
    input  logic clear,
    input  logic valid,
    output logic issue,
    output logic fire,
    output logic expired
);

    localparam int CW = $clog2(TMO + 1);

    logic          wait_q;
    logic [CW-1:0] cnt_q;

    // Counter reads 1 in the first WAIT cycle; the last acceptable WAIT cycle is TMO-1,
    // so an abandoned stage reports err exactly TMO cycles after its pulse.
    assign fire    = wait_q & valid;
    assign expired = wait_q & ~valid & (cnt_q >= CW'(TMO - 1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            issue  <= 1'b0;
            wait_q <= 1'b0;
            cnt_q  <= '0;
        end else if (clear) begin
            issue  <= 1'b0;
            wait_q <= 1'b0;
            cnt_q  <= '0;
        end else if (arm) begin
            issue  <= 1'b1;
            wait_q <= 1'b0;
            cnt_q  <= '0;
        end else if (issue) begin
            issue  <= 1'b0;
            wait_q <= 1'b1;
            cnt_q  <= CW'(1);
        end else if (wait_q) begin
            if (valid || expired) begin
                wait_q <= 1'b0;
                cnt_q  <= '0;
            end else begin
                cnt_q <= cnt_q + 1'b1;
            end
        end
    end

endmodule

// File: rtl/aes_round_sequencer.sv
// AES-128 encryption control FSM: ARK0, NR-1 full rounds, final round without MixColumns.
// Latency 2 cycles per stage with 1-cycle units (81 for NR=10); stalls on each stage's valid.
module aes_round_sequencer
    import aes_pkg::*;
#(
    parameter int NR  = AES128_NR,
    parameter int TMO = 15
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              abort,
    output logic              ready,
    output logic              busy,
    output logic              done,
    output logic              err,
    output logic [RIDX_W-1:0] round_idx,
    output logic [1:0]        ark_sel,
    output logic              SubBytesEN,
    output logic              ShiftRowsEN,
    output logic              MixColumnsEN,
    output logic              AddRoundKeyEN,
    input  logic              SubBytesValid,
    input  logic              ShiftRowsValid,
    input  logic              MixColumnsValid,
    input  logic              AddRoundKeyValid
);

    localparam logic [RIDX_W-1:0] NR_L = RIDX_W'(NR);

    state_t            state_q, state_d;
    logic [RIDX_W-1:0] round_q, round_d;
    logic [1:0]        sel_q, sel_d;
    logic              err_q, err_d;
    logic              arm, clear, valid_sel, issue, fire, expired;

    stage_handshake #(.TMO(TMO)) u_hs (
        .clk     (clk),
        .rst     (rst),
        .arm     (arm),
        .clear   (clear),
        .valid   (valid_sel),
        .issue   (issue),
        .fire    (fire),
        .expired (expired)
    );

    always_comb begin
        valid_sel = 1'b0;
        case (state_q)
            ARK0, ARK: valid_sel = AddRoundKeyValid;
            SB:        valid_sel = SubBytesValid;
            SR:        valid_sel = ShiftRowsValid;
            MC:        valid_sel = MixColumnsValid;
            default:   valid_sel = 1'b0;
        endcase
    end

    always_comb begin
        state_d = state_q;
        round_d = round_q;
        sel_d   = sel_q;
        err_d   = 1'b0;
        arm     = 1'b0;
        clear   = 1'b0;
        if (abort) begin
            state_d = IDLE;
            round_d = '0;
            sel_d   = ARK_SEL_PT;
            clear   = 1'b1;
        end else if (state_q == IDLE || state_q == FIN) begin
            // FIN doubles as an idle cycle so a new block can start back-to-back.
            state_d = IDLE;
            round_d = '0;
            sel_d   = ARK_SEL_PT;
            if (start) begin
                state_d = ARK0;
                arm     = 1'b1;
            end
        end else if (expired) begin
            state_d = IDLE;
            round_d = '0;
            sel_d   = ARK_SEL_PT;
            err_d   = 1'b1;
            clear   = 1'b1;
        end else if (fire) begin
            arm = 1'b1;
            case (state_q)
                ARK0: begin
                    state_d = SB;
                    round_d = RIDX_W'(1);
                end
                SB: state_d = SR;
                SR: begin
                    if (round_q < NR_L) begin
                        state_d = MC;
                    end else begin
                        state_d = ARK;
                        sel_d   = ARK_SEL_SR;
                    end
                end
                MC: begin
                    state_d = ARK;
                    sel_d   = ARK_SEL_MC;
                end
                ARK: begin
                    if (round_q < NR_L) begin
                        state_d = SB;
                        round_d = round_q + 1'b1;
                    end else begin
                        state_d = FIN;
                        arm     = 1'b0;
                    end
                end
                default: arm = 1'b0;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            round_q <= '0;
            sel_q   <= ARK_SEL_PT;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            round_q <= round_d;
            sel_q   <= sel_d;
            err_q   <= err_d;
        end
    end

    assign ready         = (state_q == IDLE) || (state_q == FIN);
    assign busy          = ~ready;
    assign done          = (state_q == FIN);
    assign err           = err_q;
    assign round_idx     = round_q;
    assign ark_sel       = sel_q;
    assign SubBytesEN    = issue && (state_q == SB);
    assign ShiftRowsEN   = issue && (state_q == SR);
    assign MixColumnsEN  = issue && (state_q == MC);
    assign AddRoundKeyEN = issue && (state_q == ARK0 || state_q == ARK);

endmodule

// File: tb/tb_aes_round_sequencer.sv
// Directed bench for aes_round_sequencer with behavioural stage-unit models.
module tb_aes_round_sequencer;

    localparam int NR  = 10;
    localparam int TMO = 15;

    logic       clk = 1'b0;
    logic       rst, start, abort;
    logic       ready, busy, done, err;
    logic [3:0] round_idx;
    logic [1:0] ark_sel;
    logic       SubBytesEN, ShiftRowsEN, MixColumnsEN, AddRoundKeyEN;
    logic       SubBytesValid, ShiftRowsValid, MixColumnsValid, AddRoundKeyValid;

    always #5 clk = ~clk;

    aes_round_sequencer #(.NR(NR), .TMO(TMO)) dut (
        .clk              (clk),
        .rst              (rst),
        .start            (start),
        .abort            (abort),
        .ready            (ready),
        .busy             (busy),
        .done             (done),
        .err              (err),
        .round_idx        (round_idx),
        .ark_sel          (ark_sel),
        .SubBytesEN       (SubBytesEN),
        .ShiftRowsEN      (ShiftRowsEN),
        .MixColumnsEN     (MixColumnsEN),
        .AddRoundKeyEN    (AddRoundKeyEN),
        .SubBytesValid    (SubBytesValid),
        .ShiftRowsValid   (ShiftRowsValid),
        .MixColumnsValid  (MixColumnsValid),
        .AddRoundKeyValid (AddRoundKeyValid)
    );

    int n_assert = 0;
    int n_fail   = 0;
    int cyc      = 0;
    int lat      = 1;
    bit kill_en  = 1'b0;
    int force_lo = -1, force_hi = -1;
    int start_pulse = -1;
    int p_sb, p_sr, p_mc, p_ark;
    int en_multi, n_done, n_err, done_cyc, err_cyc, err_ready, err_ridx;
    int mc_last, mc_round, sr_first;
    int en_seq[$];
    int ark_r[$];
    int ark_s[$];
    int done_list[$];
    int ready_list[$];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic clear_models();
        p_sb = 0; p_sr = 0; p_mc = 0; p_ark = 0;
        SubBytesValid = 0; ShiftRowsValid = 0; MixColumnsValid = 0; AddRoundKeyValid = 0;
    endtask

    task automatic reset_logs();
        cyc = 0; en_multi = 0; n_done = 0; n_err = 0; done_cyc = -1; err_cyc = -1;
        err_ready = -1; err_ridx = -1; mc_last = -1; mc_round = -1; sr_first = -1;
        en_seq.delete(); ark_r.delete(); ark_s.delete(); done_list.delete(); ready_list.delete();
    endtask

    // Advance one cycle: update stage models from this cycle's enables, then observe.
    task automatic tick();
        logic e_sb, e_sr, e_mc, e_ark;
        e_sb = SubBytesEN; e_sr = ShiftRowsEN; e_mc = MixColumnsEN; e_ark = AddRoundKeyEN;
        @(posedge clk);
        #1;
        cyc++;
        p_sb  = e_sb  ? lat : (p_sb  > 0 ? p_sb  - 1 : 0);
        p_sr  = e_sr  ? lat : (p_sr  > 0 ? p_sr  - 1 : 0);
        p_mc  = e_mc  ? lat : (p_mc  > 0 ? p_mc  - 1 : 0);
        p_ark = e_ark ? lat : (p_ark > 0 ? p_ark - 1 : 0);
        SubBytesValid    = (p_sb == 1);
        ShiftRowsValid   = (p_sr == 1) || (cyc >= force_lo && cyc <= force_hi);
        MixColumnsValid  = (p_mc == 1) && !(kill_en && mc_round == 4);
        AddRoundKeyValid = (p_ark == 1);
        if (int'(SubBytesEN) + int'(ShiftRowsEN) + int'(MixColumnsEN) + int'(AddRoundKeyEN) > 1)
            en_multi++;
        if (SubBytesEN) en_seq.push_back(0);
        if (ShiftRowsEN) begin
            en_seq.push_back(1);
            if (sr_first < 0) sr_first = cyc;
        end
        if (MixColumnsEN) begin
            en_seq.push_back(2);
            mc_last  = cyc;
            mc_round = int'(round_idx);
        end
        if (AddRoundKeyEN) begin
            en_seq.push_back(3);
            ark_r.push_back(int'(round_idx));
            ark_s.push_back(int'(ark_sel));
        end
        if (done) begin
            n_done++;
            done_cyc = cyc;
            done_list.push_back(cyc);
        end
        if (err) begin
            n_err++;
            err_cyc   = cyc;
            err_ready = int'(ready);
            err_ridx  = int'(round_idx);
        end
        if (ready) ready_list.push_back(cyc);
    endtask

    task automatic run_until(input int c);
        while (cyc < c) tick();
    endtask

    task automatic launch_and_wait(input int bound);
        int g;
        g = 0;
        start = 1'b1;
        tick();
        start = 1'b0;
        while (n_done == 0 && n_err == 0 && g < bound) begin
            start = (cyc == start_pulse);
            tick();
            g++;
        end
        start = 1'b0;
    endtask

    function automatic int seq_mismatch();
        int exp_q[$];
        int m;
        exp_q.push_back(3);
        for (int r = 1; r < NR; r++) begin
            exp_q.push_back(0); exp_q.push_back(1); exp_q.push_back(2); exp_q.push_back(3);
        end
        exp_q.push_back(0); exp_q.push_back(1); exp_q.push_back(3);
        m = (exp_q.size() == en_seq.size()) ? 0 : 1000;
        for (int i = 0; i < exp_q.size() && i < en_seq.size(); i++)
            if (exp_q[i] != en_seq[i]) m++;
        for (int i = 0; i < ark_r.size(); i++) begin
            if (ark_r[i] != i) m++;
            if (ark_s[i] != (i == 0 ? 0 : (i == NR ? 2 : 1))) m++;
        end
        if (ark_r.size() != NR + 1) m += 1000;
        return m;
    endfunction

    initial begin
        rst = 1'b1; start = 1'b0; abort = 1'b0;
        clear_models();
        reset_logs();
        @(posedge clk);
        #1;
        chk("reset_ready", ready, 1);
        chk("reset_busy", busy, 0);
        chk("reset_done_err", {done, err}, 0);
        chk("reset_round_sel", {round_idx, ark_sel}, 0);
        chk("reset_en", {SubBytesEN, ShiftRowsEN, MixColumnsEN, AddRoundKeyEN}, 0);
        rst = 1'b0;
        tick(); tick();

        // Nominal block with 1-cycle stage units
        reset_logs();
        launch_and_wait(200);
        chk("nom_done_cycle", done_cyc, 81);
        chk("nom_seq_mismatch", seq_mismatch(), 0);
        chk("nom_multi_en", en_multi, 0);
        tick();
        chk("nom_idle_after", {ready, busy, done}, 3'b100);

        // 3-cycle stage units, spurious ShiftRowsValid in SB WAIT, ignored start in cycle 20
        lat = 3; force_lo = 6; force_hi = 7; start_pulse = 20;
        reset_logs();
        launch_and_wait(300);
        chk("lat3_done_cycle", done_cyc, 161);
        chk("lat3_multi_en", en_multi, 0);
        chk("lat3_first_sr", sr_first, 9);
        chk("lat3_seq_mismatch", seq_mismatch(), 0);
        repeat (5) tick();
        chk("lat3_single_done", n_done, 1);
        lat = 1; force_lo = -1; force_hi = -1; start_pulse = -1;

        // MixColumns never answers in round 4
        kill_en = 1'b1;
        reset_logs();
        launch_and_wait(200);
        chk("tmo_mc_cycle", mc_last, 31);
        chk("tmo_err_delay", err_cyc - mc_last, TMO);
        chk("tmo_err_ready_ridx", {err_ready[0], err_ridx[3:0]}, 5'b10000);
        repeat (5) tick();
        chk("tmo_no_done", n_done, 0);
        chk("tmo_single_err", n_err, 1);
        kill_en = 1'b0; mc_round = -1;
        clear_models();
        reset_logs();
        launch_and_wait(200);
        chk("tmo_restart_done", done_cyc, 81);
        chk("tmo_restart_no_err", n_err, 0);

        // Abort in cycle 40 then restart in cycle 41
        tick();
        reset_logs();
        start = 1'b1;
        tick();
        start = 1'b0;
        run_until(40);
        abort = 1'b1;
        tick();
        abort = 1'b0;
        chk("abort_ready", ready, 1);
        chk("abort_en", {SubBytesEN, ShiftRowsEN, MixColumnsEN, AddRoundKeyEN}, 0);
        chk("abort_round_sel", {round_idx, ark_sel}, 0);
        clear_models();
        launch_and_wait(200);
        chk("abort_restart_done", done_cyc, 122);
        chk("abort_no_err", n_err, 0);
        chk("abort_single_done", n_done, 1);

        // Asynchronous reset in cycle 50
        tick();
        reset_logs();
        start = 1'b1;
        tick();
        start = 1'b0;
        run_until(50);
        chk("prerst_busy", busy, 1);
        #2 rst = 1'b1;
        #1;
        chk("arst_ready_busy", {ready, busy}, 2'b10);
        chk("arst_done_err", {done, err}, 0);
        chk("arst_round_sel", {round_idx, ark_sel}, 0);
        chk("arst_en", {SubBytesEN, ShiftRowsEN, MixColumnsEN, AddRoundKeyEN}, 0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        clear_models();
        repeat (100) tick();
        chk("arst_no_done", n_done, 0);

        // start held high: back-to-back blocks
        reset_logs();
        start = 1'b1;
        run_until(245);
        start = 1'b0;
        chk("b2b_done_count", done_list.size(), 3);
        chk("b2b_done_cycles", (done_list.size() == 3) ?
            ((done_list[0] == 81) && (done_list[1] == 162) && (done_list[2] == 243)) : 0, 1);
        chk("b2b_ready_count", ready_list.size(), 3);
        chk("b2b_ready_cycles", (ready_list.size() == 3) ?
            ((ready_list[0] == 81) && (ready_list[1] == 162) && (ready_list[2] == 243)) : 0, 1);
        chk("b2b_multi_en", en_multi, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
